burst_ram: RTL and testbench
============================

BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 15, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port CS  input  1  chip select; 1 enables an access or burst beat this cycle.
REQ-006 SHALL have port RW_  input  1  1 = read, 0 = write.
REQ-007 SHALL have port ADDR  input  ADDR_W  start address of a single access or a burst.
REQ-008 SHALL have port DATA_IN  input  DATA_W  write data, sampled on every write beat.
REQ-009 SHALL have port BURST  input  1  1 = start an auto-increment burst at ADDR.
REQ-010 SHALL have port BLEN  input  ADDR_W  burst length minus one (beats = BLEN+1).
REQ-011 SHALL have port CLR  input  1  start a clear sweep that zeroes the whole array.
REQ-012 SHALL have port DATA_OUT  output  DATA_W  registered read data.
REQ-013 SHALL have port VALID  output  1  DATA_OUT holds new read data this cycle.
REQ-014 SHALL have port BUSY  output  1  1 while in CLEAR or BURST state.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse when a burst or clear completes.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, BURST.
REQ-017 In IDLE, request priority SHALL be CLR, then CS&BURST, then CS single access.
REQ-018 IDLE single read (CS=1, BURST=0, RW_=1): DATA_OUT = mem[ADDR], VALID=1 on the next cycle (latency 1).
REQ-019 IDLE single write (CS=1, BURST=0, RW_=0): mem[ADDR] <= DATA_IN at the edge; VALID stays 0.
REQ-020 CS=0 with no active operation: no access, DATA_OUT holds its last value, VALID=0.
REQ-021 CLR in IDLE: enter CLEAR; write 0 to addresses 0..DEPTH-1, one per cycle, independent of CS.
REQ-022 CLEAR SHALL last exactly DEPTH cycles, then return to IDLE with DONE=1 for one cycle.
REQ-023 Burst accept (IDLE, CS=1, BURST=1): accept cycle SHALL be beat 0 at ADDR; RW_ and BLEN latched.
REQ-024 If BLEN=0, the burst is a single beat: remain IDLE, DONE pulses on the following cycle.
REQ-025 If BLEN>0, enter BURST with pointer = ADDR+1, remaining beats = BLEN.
REQ-026 In BURST, each cycle with CS=1 SHALL perform one beat at pointer, then increment pointer and decrement remaining.
REQ-027 In BURST, CS=0 SHALL stall: no access, pointer and remaining held, VALID=0.
REQ-028 Pointer SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-029 Read beats SHALL produce VALID=1 with mem[pointer] one cycle later; write beats store DATA_IN.
REQ-030 On the final beat, the block SHALL return to IDLE and DONE SHALL pulse on the next cycle.
REQ-031 While BUSY=1, ADDR, BLEN, BURST, RW_ and CLR SHALL be ignored; DATA_IN is used on write beats only.
REQ-032 DONE and VALID SHALL never be asserted for more than one cycle per completion or beat.

Reset
REQ-033 RST_N=0 SHALL immediately force: FSM=IDLE, DATA_OUT=0, VALID=0, BUSY=0, DONE=0, pointer and count = 0.
REQ-034 Memory array contents SHALL NOT be reset; CLR is the only clearing mechanism.
REQ-035 Reset during BURST or CLEAR SHALL abort without DONE; beats already written are retained.

Structure
REQ-036 Package burst_ram_pkg SHALL hold the state enum and the default DATA_W/ADDR_W constants.
REQ-037 Sub-module burst_ram_addr_ctr SHALL implement the loadable, enable-gated, wrapping ADDR_W pointer.
REQ-038 Array SHALL be a single-port, synchronous-write, registered-read memory inferable as block RAM.

Verification
REQ-039 Reset, pulse CLR -> BUSY=1 for 64 cycles, DONE pulse once, every subsequent read returns 0.
REQ-040 Write 0x1234 to addr 5, then read addr 5 -> DATA_OUT=0x1234 with VALID=1 exactly one cycle after the read.
REQ-041 Write burst ADDR=62, BLEN=3, data 1,2,3,4 -> addresses 62,63,0,1 written; read burst returns 1,2,3,4 on 4 VALID cycles.
REQ-042 Read burst BLEN=3 with CS=0 for 2 cycles mid-burst -> 2-cycle VALID gap, no address skipped, DONE after 4th beat.
REQ-043 RST_N low mid-burst -> all outputs 0 immediately, no DONE, already-written beats read back intact.
REQ-044 Idle with CS=0 for 10 cycles after a read -> DATA_OUT unchanged, VALID=0 throughout.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared constants for the burst RAM: default geometry and FSM state encodings.
package burst_ram_pkg;
  localparam int DATA_W_DEF = 15;
  localparam int ADDR_W_DEF = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
endpackage

// File: rtl/burst_ram_addr_ctr.sv
// Loadable, enable-gated address pointer; wraps naturally at 2**W.
module burst_ram_addr_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] ptr
);

  // Load has priority over increment; the increment overflows DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (load) ptr <= load_val;
    else if (en)   ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/burst_ram.sv
// Single-port RAM with single accesses, auto-increment bursts and a full clear sweep.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CS,
  input  logic              RW_,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              BURST,
  input  logic [ADDR_W-1:0] BLEN,
  input  logic              CLR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              DONE
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr, rem, rem_nxt;
  logic              rw_l, rw_nxt, done_nxt;
  logic              acc_en, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              ld, inc;
  logic [ADDR_W-1:0] ld_val;

  burst_ram_addr_ctr #(.W(ADDR_W)) u_ctr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (ld),
    .load_val(ld_val),
    .en      (inc),
    .ptr     (ptr)
  );

  // Next-state and single memory-port arbitration. The burst accept cycle is beat 0.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    rw_nxt    = rw_l;
    done_nxt  = 1'b0;
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = ptr;
    acc_wdata = DATA_IN;
    ld        = 1'b0;
    ld_val    = '0;
    inc       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CLR) begin
          state_nxt = ST_CLEAR;
          ld        = 1'b1;
        end else if (CS) begin
          acc_en   = 1'b1;
          acc_we   = !RW_;
          acc_addr = ADDR;
          if (BURST) begin
            rw_nxt = RW_;
            if (BLEN == '0) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = ST_BURST;
              ld        = 1'b1;
              ld_val    = ADDR + 1'b1;
              rem_nxt   = BLEN;
            end
          end
        end
      end
      ST_CLEAR: begin
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = '0;
        inc       = 1'b1;
        if (&ptr) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      ST_BURST: begin
        // CS low stalls the burst: pointer and remaining count hold.
        if (CS) begin
          acc_en  = 1'b1;
          acc_we  = !rw_l;
          inc     = 1'b1;
          rem_nxt = rem - 1'b1;
          if (rem == ADDR_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state and registered read port; reset aborts any sweep or burst silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      rem      <= '0;
      rw_l     <= 1'b0;
      DONE     <= 1'b0;
      VALID    <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      rw_l  <= rw_nxt;
      DONE  <= done_nxt;
      VALID <= acc_en && !acc_we;
      if (acc_en && !acc_we) DATA_OUT <= mem[acc_addr];
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (acc_en && acc_we) mem[acc_addr] <= acc_wdata;
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_burst_ram.sv
// Directed self-checking bench for burst_ram.
module tb_burst_ram;
  localparam int DW = 15;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST_N, CS, RW_, BURST, CLR;
  logic [AW-1:0] ADDR, BLEN;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT;
  logic          VALID, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  burst_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .RW_(RW_), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .BURST(BURST), .BLEN(BLEN), .CLR(CLR),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic single(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CS = 1'b1; RW_ = rd; BURST = 1'b0; ADDR = a; DATA_IN = d;
    tick();
    CS = 1'b0;
  endtask

  initial begin
    int n;
    RST_N = 1'b0; CS = 1'b0; RW_ = 1'b1; BURST = 1'b0; CLR = 1'b0;
    ADDR = '0; BLEN = '0; DATA_IN = '0;
    #3;
    chk("rst_dout",  DATA_OUT, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_done",  DONE, 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Clear sweep: BUSY for exactly 64 cycles, then a single DONE pulse.
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    n = 0;
    while (BUSY && n < 200) begin
      if (DONE) chk("clr_done_early", DONE, 0);
      n++;
      tick();
    end
    chk("clr_busy_cycles", n, 64);
    chk("clr_done", DONE, 1);
    tick();
    chk("clr_done_once", DONE, 0);
    single(1'b1, 6'd0, '0);  chk("clr_rd0", DATA_OUT, 0);  chk("clr_rd0_v", VALID, 1);
    single(1'b1, 6'd37, '0); chk("clr_rd37", DATA_OUT, 0);
    single(1'b1, 6'd63, '0); chk("clr_rd63", DATA_OUT, 0);

    // Single write then read with latency 1.
    single(1'b0, 6'd5, 15'h1234);
    chk("wr_valid", VALID, 0);
    single(1'b1, 6'd5, '0);
    chk("rd5_data",  DATA_OUT, 15'h1234);
    chk("rd5_valid", VALID, 1);

    // Idle with CS=0: output holds, VALID stays low.
    for (int i = 0; i < 10; i++) begin
      ADDR = AW'(i);
      tick();
      chk("idle_valid", VALID, 0);
      chk("idle_dout",  DATA_OUT, 15'h1234);
    end

    // Write burst 62..1 with wrap; ADDR changes mid-burst must be ignored.
    CS = 1'b1; RW_ = 1'b0; BURST = 1'b1; ADDR = 6'd62; BLEN = 6'd3; DATA_IN = 15'd1;
    tick();
    chk("wb_busy", BUSY, 1);
    BURST = 1'b0; ADDR = 6'd7; BLEN = 6'd0; RW_ = 1'b1; DATA_IN = 15'd2;
    tick();
    DATA_IN = 15'd3;
    tick();
    chk("wb_no_done", DONE, 0);
    DATA_IN = 15'd4;
    tick();
    chk("wb_done", DONE, 1);
    chk("wb_idle", BUSY, 0);
    CS = 1'b0;
    tick();
    chk("wb_done_once", DONE, 0);
    single(1'b1, 6'd62, '0); chk("rd62", DATA_OUT, 1);
    single(1'b1, 6'd63, '0); chk("rd63", DATA_OUT, 2);
    single(1'b1, 6'd0, '0);  chk("rd0",  DATA_OUT, 3);
    single(1'b1, 6'd1, '0);  chk("rd1",  DATA_OUT, 4);
    single(1'b1, 6'd7, '0);  chk("rd7_untouched", DATA_OUT, 0);

    // Read burst with a two-cycle stall in the middle.
    CS = 1'b1; RW_ = 1'b1; BURST = 1'b1; ADDR = 6'd62; BLEN = 6'd3;
    tick();
    chk("rb_b0", DATA_OUT, 1); chk("rb_v0", VALID, 1);
    BURST = 1'b0; ADDR = 6'd5; RW_ = 1'b0;
    tick();
    chk("rb_b1", DATA_OUT, 2); chk("rb_v1", VALID, 1);
    CS = 1'b0;
    tick();
    chk("rb_stall_v", VALID, 0); chk("rb_stall_busy", BUSY, 1);
    tick();
    chk("rb_stall_v2", VALID, 0); chk("rb_stall_dout", DATA_OUT, 2);
    CS = 1'b1;
    tick();
    chk("rb_b2", DATA_OUT, 3); chk("rb_no_done", DONE, 0);
    tick();
    chk("rb_b3", DATA_OUT, 4); chk("rb_v3", VALID, 1); chk("rb_done", DONE, 1);
    CS = 1'b0;
    tick();
    chk("rb_end_v", VALID, 0); chk("rb_end_done", DONE, 0);
    single(1'b1, 6'd5, '0); chk("rd5_kept", DATA_OUT, 15'h1234);

    // Single-beat burst (BLEN=0) stays idle and pulses DONE next cycle.
    CS = 1'b1; RW_ = 1'b0; BURST = 1'b1; ADDR = 6'd10; BLEN = 6'd0; DATA_IN = 15'h55;
    tick();
    CS = 1'b0; BURST = 1'b0;
    chk("b0_busy", BUSY, 0); chk("b0_done", DONE, 1);
    tick();
    chk("b0_done_once", DONE, 0);
    single(1'b1, 6'd10, '0); chk("rd10", DATA_OUT, 15'h55);

    // Reset mid-burst: outputs drop at once, no DONE, written beats kept.
    CS = 1'b1; RW_ = 1'b0; BURST = 1'b1; ADDR = 6'd20; BLEN = 6'd5; DATA_IN = 15'hA;
    tick();
    BURST = 1'b0; DATA_IN = 15'hB;
    tick();
    chk("mid_busy", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk("mrst_dout", DATA_OUT, 0);
    chk("mrst_valid", VALID, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_done", DONE, 0);
    CS = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    chk("mrst_no_done", DONE, 0);
    chk("mrst_idle", BUSY, 0);
    single(1'b1, 6'd20, '0); chk("rd20", DATA_OUT, 15'hA);
    single(1'b1, 6'd21, '0); chk("rd21", DATA_OUT, 15'hB);
    single(1'b1, 6'd22, '0); chk("rd22_clear", DATA_OUT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
